// File: rtl/mem_load_unit.sv
// MEM-stage load unit: issues a word-aligned bus read, stalls until ack, then extracts and extends the result.
// Optional misaligned-load exception (AdEL) is enabled with `define LOAD_ALIGN_CHECK_EN.
module mem_load_unit (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] M_readAddr,
    input  logic [9:0]  M_instrType,
    input  logic        M_memReadEn,
    output logic        bus_rd_req,
    output logic [31:0] bus_addr,
    input  logic        bus_rd_ack,
    input  logic [31:0] bus_rd_data,
    output logic [31:0] loadData,
    output logic        loadValid,
    output logic        stall,
    output logic        excValid,
    output logic [4:0]  excCode
);

    // Instruction-type encodings shared with the decode stage.
    localparam logic [9:0] TYPE_LW  = 10'b00_0000_0001;
    localparam logic [9:0] TYPE_LH  = 10'b00_0000_0010;
    localparam logic [9:0] TYPE_LHU = 10'b00_0000_0100;
    localparam logic [9:0] TYPE_LB  = 10'b00_0000_1000;
    localparam logic [9:0] TYPE_LBU = 10'b00_0001_0000;

    localparam logic [4:0] EXC_ADEL = 5'd4;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]  state;
    logic [9:0]  latchedType;
    logic [1:0]  latchedOff;
    logic        isLoad;
    logic        isHalf;
    logic        misaligned;
    logic        accept;
    logic [31:0] extracted;
    logic [15:0] halfSel;
    logic [7:0]  byteSel;

    assign isHalf = (M_instrType == TYPE_LH) || (M_instrType == TYPE_LHU);
    assign isLoad = (M_instrType == TYPE_LW) || isHalf ||
                    (M_instrType == TYPE_LB) || (M_instrType == TYPE_LBU);
    assign accept = (state == S_IDLE) && M_memReadEn && isLoad;

`ifdef LOAD_ALIGN_CHECK_EN
    assign misaligned = ((M_instrType == TYPE_LW) && (M_readAddr[1:0] != 2'b00)) ||
                        (isHalf && M_readAddr[0]);
`else
    assign misaligned = 1'b0;
`endif

    assign stall = accept || (state == S_WAIT);

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        halfSel   = latchedOff[1] ? bus_rd_data[31:16] : bus_rd_data[15:0];
        byteSel   = bus_rd_data[7:0];
        extracted = bus_rd_data;
        case (latchedOff)
            2'd1:    byteSel = bus_rd_data[15:8];
            2'd2:    byteSel = bus_rd_data[23:16];
            2'd3:    byteSel = bus_rd_data[31:24];
            default: byteSel = bus_rd_data[7:0];
        endcase
        case (latchedType)
            TYPE_LH:  extracted = {{16{halfSel[15]}}, halfSel};
            TYPE_LHU: extracted = {16'd0, halfSel};
            TYPE_LB:  extracted = {{24{byteSel[7]}}, byteSel};
            TYPE_LBU: extracted = {24'd0, byteSel};
            default:  extracted = bus_rd_data;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            latchedType <= '0;
            latchedOff  <= '0;
            bus_rd_req  <= 1'b0;
            bus_addr    <= '0;
            loadData    <= '0;
            loadValid   <= 1'b0;
        end else begin
            loadValid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        latchedType <= M_instrType;
                        latchedOff  <= M_readAddr[1:0];
                        if (misaligned) begin
                            loadData  <= '0;
                            loadValid <= 1'b1;
                            state     <= S_DONE;
                        end else begin
                            bus_rd_req <= 1'b1;
                            bus_addr   <= {M_readAddr[31:2], 2'b00};
                            state      <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (bus_rd_ack) begin
                        bus_rd_req <= 1'b0;
                        loadData   <= extracted;
                        loadValid  <= 1'b1;
                        state      <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef LOAD_ALIGN_CHECK_EN
    // Exception is reported alongside the loadValid pulse of the aborted load.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            excValid <= 1'b0;
            excCode  <= '0;
        end else if (accept && misaligned) begin
            excValid <= 1'b1;
            excCode  <= EXC_ADEL;
        end else begin
            excValid <= 1'b0;
            excCode  <= '0;
        end
    end
`else
    assign excValid = 1'b0;
    assign excCode  = 5'd0;
`endif

endmodule

// File: tb/tb_mem_load_unit.sv
// Self-checking bench for mem_load_unit: directed plan loads plus randomized loads against an arithmetic model.
// Honors `define LOAD_ALIGN_CHECK_EN to match the DUT build.
module tb_mem_load_unit;

    localparam logic [9:0] LW  = 10'b00_0000_0001;
    localparam logic [9:0] LH  = 10'b00_0000_0010;
    localparam logic [9:0] LHU = 10'b00_0000_0100;
    localparam logic [9:0] LB  = 10'b00_0000_1000;
    localparam logic [9:0] LBU = 10'b00_0001_0000;
    localparam logic [9:0] NONLOAD = 10'b10_0000_0000;

    logic        clk;
    logic        reset_n;
    logic [31:0] M_readAddr;
    logic [9:0]  M_instrType;
    logic        M_memReadEn;
    logic        bus_rd_req;
    logic [31:0] bus_addr;
    logic        bus_rd_ack;
    logic [31:0] bus_rd_data;
    logic [31:0] loadData;
    logic        loadValid;
    logic        stall;
    logic        excValid;
    logic [4:0]  excCode;

    int total = 0;
    int bad   = 0;

    mem_load_unit dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .M_readAddr  (M_readAddr),
        .M_instrType (M_instrType),
        .M_memReadEn (M_memReadEn),
        .bus_rd_req  (bus_rd_req),
        .bus_addr    (bus_addr),
        .bus_rd_ack  (bus_rd_ack),
        .bus_rd_data (bus_rd_data),
        .loadData    (loadData),
        .loadValid   (loadValid),
        .stall       (stall),
        .excValid    (excValid),
        .excCode     (excCode)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: shift the word so the addressed unit sits at bit 0, then extend.
    function automatic logic [31:0] refLoad(input logic [9:0] t, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] sh;
        int unsigned byteIdx;
        int unsigned halfIdx;
        byteIdx = a % 4;
        halfIdx = (a % 4) / 2;
        if (t == LH || t == LHU) begin
            sh = d >> (16 * halfIdx);
            if (t == LH) return 32'($signed(sh[15:0]));
            return 32'(sh[15:0]);
        end
        if (t == LB || t == LBU) begin
            sh = d >> (8 * byteIdx);
            if (t == LB) return 32'($signed(sh[7:0]));
            return 32'(sh[7:0]);
        end
        return d;
    endfunction

    // Starts at posedge+1 with the unit idle; ack arrives k cycles after acceptance.
    task automatic runLoad(input string name, input logic [9:0] t, input logic [31:0] a,
                           input logic [31:0] d, input int k);
        int stallCycles;
        int earlyValid;
        logic [31:0] expData;
        logic [31:0] expAddr;
        expData = refLoad(t, a, d);
        expAddr = a & 32'hFFFF_FFFC;
        stallCycles = 0;
        earlyValid = 0;
        M_instrType = t;
        M_readAddr  = a;
        M_memReadEn = 1'b1;
        @(negedge clk);
        if (stall === 1'b1) stallCycles++;
        @(posedge clk); #1;
        M_memReadEn = 1'b0;
        M_readAddr  = $urandom;
        for (int i = 1; i <= k; i++) begin
            if (i == k) begin
                bus_rd_ack  = 1'b1;
                bus_rd_data = d;
            end
            @(negedge clk);
            if (stall === 1'b1) stallCycles++;
            if (loadValid !== 1'b0) earlyValid++;
            total++;
            if (bus_rd_req !== 1'b1 || bus_addr !== expAddr) begin
                bad++;
                $display("FAIL %s wait%0d: req=%b addr=%h, required req=1 addr=%h", name, i, bus_rd_req, bus_addr, expAddr);
            end
            @(posedge clk); #1;
            bus_rd_ack  = 1'b0;
            bus_rd_data = $urandom;
        end
        @(negedge clk);
        total++;
        if (loadValid !== 1'b1 || loadData !== expData || stall !== 1'b0 || bus_rd_req !== 1'b0) begin
            bad++;
            $display("FAIL %s done: valid=%b data=%h stall=%b req=%b, required valid=1 data=%h stall=0 req=0",
                     name, loadValid, loadData, stall, bus_rd_req, expData);
        end
        total++;
        if (excValid !== 1'b0 || excCode !== 5'd0) begin
            bad++;
            $display("FAIL %s exc: excValid=%b excCode=%0d, required 0/0", name, excValid, excCode);
        end
        @(posedge clk); #1;
        @(negedge clk);
        total++;
        if (loadValid !== 1'b0 || loadData !== expData) begin
            bad++;
            $display("FAIL %s after: valid=%b data=%h, required valid=0 data=%h", name, loadValid, loadData, expData);
        end
        total++;
        if (stallCycles != k + 1 || earlyValid != 0) begin
            bad++;
            $display("FAIL %s stall: stallCycles=%0d earlyValid=%0d, required %0d and 0", name, stallCycles, earlyValid, k + 1);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        M_readAddr = '0; M_instrType = '0; M_memReadEn = 1'b0;
        bus_rd_ack = 1'b0; bus_rd_data = '0;
        #3;
        total++;
        if (bus_rd_req !== 1'b0 || bus_addr !== 32'd0 || loadData !== 32'd0 || loadValid !== 1'b0 ||
            excValid !== 1'b0 || excCode !== 5'd0 || stall !== 1'b0) begin
            bad++;
            $display("FAIL reset: req=%b addr=%h data=%h valid=%b exc=%b code=%0d stall=%b, required all 0",
                     bus_rd_req, bus_addr, loadData, loadValid, excValid, excCode, stall);
        end
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_plan_loads;
        runLoad("lw_1004", LW, 32'h0000_1004, 32'h89AB_CDEF, 1);
        runLoad("lb_2003", LB, 32'h0000_2003, 32'h80FF_1234, 1);
        runLoad("lbu_2003", LBU, 32'h0000_2003, 32'h80FF_1234, 2);
        runLoad("lh_3002", LH, 32'h0000_3002, 32'hF00D_8001, 1);
        runLoad("lhu_3000", LHU, 32'h0000_3000, 32'hF00D_8001, 3);
        runLoad("lw_slow", LW, 32'h0000_4000, 32'h1357_9BDF, 5);
    endtask

    task automatic test_ignored_inputs;
        // Ack while idle must not start anything.
        bus_rd_ack = 1'b1; bus_rd_data = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        bus_rd_ack = 1'b0;
        @(negedge clk);
        total++;
        if (loadValid !== 1'b0 || bus_rd_req !== 1'b0) begin
            bad++;
            $display("FAIL idle_ack: valid=%b req=%b, required 0/0", loadValid, bus_rd_req);
        end
        // Non-load with read enable: no stall, no request.
        M_instrType = NONLOAD; M_readAddr = 32'h0000_5000; M_memReadEn = 1'b1;
        @(negedge clk);
        total++;
        if (stall !== 1'b0) begin
            bad++;
            $display("FAIL nonload_stall: stall=%b, required 0", stall);
        end
        @(posedge clk); #1;
        M_memReadEn = 1'b0;
        @(negedge clk);
        total++;
        if (bus_rd_req !== 1'b0 || loadValid !== 1'b0) begin
            bad++;
            $display("FAIL nonload_req: req=%b valid=%b, required 0/0", bus_rd_req, loadValid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_in_wait;
        int validSeen;
        validSeen = 0;
        M_instrType = LW; M_readAddr = 32'h0000_6000; M_memReadEn = 1'b1;
        @(posedge clk); #1;
        M_memReadEn = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        total++;
        if (bus_rd_req !== 1'b0 || stall !== 1'b0) begin
            bad++;
            $display("FAIL reset_wait: req=%b stall=%b, required 0/0", bus_rd_req, stall);
        end
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
        bus_rd_ack = 1'b1; bus_rd_data = 32'h1111_2222;
        @(posedge clk); #1;
        bus_rd_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (loadValid !== 1'b0) validSeen++;
        end
        total++;
        if (validSeen != 0) begin
            bad++;
            $display("FAIL late_ack: valid pulses=%0d, required 0", validSeen);
        end
        @(posedge clk); #1;
        runLoad("lw_after_reset", LW, 32'h0000_7008, 32'hCAFE_F00D, 2);
    endtask

    task automatic test_misaligned_lw;
`ifdef LOAD_ALIGN_CHECK_EN
        int reqSeen;
        reqSeen = 0;
        M_instrType = LW; M_readAddr = 32'h0000_1002; M_memReadEn = 1'b1;
        @(negedge clk);
        total++;
        if (stall !== 1'b1) begin
            bad++;
            $display("FAIL misalign_stall: stall=%b, required 1", stall);
        end
        @(posedge clk); #1;
        M_memReadEn = 1'b0;
        @(negedge clk);
        if (bus_rd_req !== 1'b0) reqSeen++;
        total++;
        if (excValid !== 1'b1 || excCode !== 5'd4 || loadValid !== 1'b1 || loadData !== 32'd0 || stall !== 1'b0) begin
            bad++;
            $display("FAIL misalign_done: exc=%b code=%0d valid=%b data=%h stall=%b, required 1/4/1/0/0",
                     excValid, excCode, loadValid, loadData, stall);
        end
        @(posedge clk); #1;
        @(negedge clk);
        if (bus_rd_req !== 1'b0) reqSeen++;
        total++;
        if (excValid !== 1'b0 || loadValid !== 1'b0 || reqSeen != 0) begin
            bad++;
            $display("FAIL misalign_after: exc=%b valid=%b reqSeen=%0d, required 0/0/0", excValid, loadValid, reqSeen);
        end
        @(posedge clk); #1;
`else
        runLoad("lw_1002_noalign", LW, 32'h0000_1002, 32'h0BAD_F00D, 1);
        runLoad("lh_3003_noalign", LH, 32'h0000_3003, 32'h8765_4321, 1);
`endif
    endtask

    task automatic test_random;
        logic [9:0]  t;
        logic [31:0] a;
        int unsigned sel;
        for (int n = 0; n < 40; n++) begin
            sel = $urandom_range(0, 4);
            case (sel)
                0: t = LW;
                1: t = LH;
                2: t = LHU;
                3: t = LB;
                default: t = LBU;
            endcase
            a = $urandom;
`ifdef LOAD_ALIGN_CHECK_EN
            if (t == LW) a[1:0] = 2'b00;
            if (t == LH || t == LHU) a[0] = 1'b0;
`endif
            runLoad($sformatf("rand%0d", n), t, a, $urandom, $urandom_range(1, 4));
        end
    endtask

    initial begin
        test_reset;
        test_plan_loads;
        test_ignored_inputs;
        test_reset_in_wait;
        test_misaligned_lw;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
